// File: rtl/uart_pkg.sv
// Shared UART link definitions: controller state encoding and the default
// byte-gap budget derived from the system clock and baud rate.
package uart_pkg;

  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    WAIT_HI = 2'd1,
    WRITE   = 2'd2
  } uart_state_e;

  localparam int unsigned CLK_FREQ     = 50_000_000;
  localparam int unsigned BAUD         = 115_200;
  localparam int unsigned BITS_PER_GAP = 12;

  // About one character time (plus margin) expressed in system clock cycles.
  function automatic int unsigned gap_cycles_f(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq / baud) * BITS_PER_GAP;
  endfunction

  localparam int unsigned GAP_CYCLES_DEF = gap_cycles_f(CLK_FREQ, BAUD);

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles from a clear and pulses o_expire
// in the enabled cycle that finds the count at GAP_CYCLES-1 (GAP_CYCLES >= 2).
module uart_gap_timer
  import uart_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic SYS_CLK,
  input  logic RST_N,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned   TW = $clog2(GAP_CYCLES);
  localparam logic [TW-1:0] TC = TW'(GAP_CYCLES - 1);

  logic [TW-1:0] r_count;
  logic          w_tc;

  assign w_tc     = (r_count == TC);
  assign o_expire = i_enable && w_tc;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: pairs received bytes low-first into 16-bit words for
// the RX FIFO, drops stale or errored half-words, counts errors and overflows.
//
//   state   | meaning
//   WAIT_LO | idle, next good byte becomes the low byte
//   WAIT_HI | low byte held, gap timer running, next good byte completes the word
//   WRITE   | word complete but FIFO full (or a write just issued), retrying
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             SYS_CLK,
  input  logic             RST_N,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_err,
  input  logic             wr_full,
  output logic             wr_clk,
  output logic             wr_req,
  output logic [15:0]      wr_data,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  uart_state_e      r_state, w_state_nxt;
  logic [7:0]       r_lo, w_lo_nxt;
  logic [15:0]      r_wr_data, w_wr_data_nxt;
  logic             r_wr_req, w_wr_req_nxt;
  logic             r_drop, w_drop_nxt;
  logic [CNT_W-1:0] r_err_cnt, r_ovf_cnt;
  logic             w_byte_ok, w_byte_err;
  logic             w_timer_clr, w_timer_en, w_expire;
  logic             w_ovf_inc;

  assign w_byte_ok  = rx_valid && !rx_err;
  assign w_byte_err = rx_valid && rx_err;
  assign w_timer_en = (r_state == WAIT_HI) && !rx_valid;

  uart_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .SYS_CLK (SYS_CLK),
    .RST_N   (RST_N),
    .i_clear (w_timer_clr),
    .i_enable(w_timer_en),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_lo_nxt      = r_lo;
    w_wr_data_nxt = r_wr_data;
    w_wr_req_nxt  = 1'b0;
    w_drop_nxt    = 1'b0;
    w_timer_clr   = 1'b0;
    w_ovf_inc     = 1'b0;
    case (r_state)
      WAIT_LO: begin
        if (w_byte_ok) begin
          w_lo_nxt    = rx_data;
          w_timer_clr = 1'b1;
          w_state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (w_byte_err) begin
          w_lo_nxt    = 8'h00;
          w_drop_nxt  = 1'b1;
          w_state_nxt = WAIT_LO;
        end else if (w_byte_ok) begin
          w_wr_data_nxt = {rx_data, r_lo};
          // A request already on the bus this cycle forces a one-cycle deferral.
          if (wr_full || r_wr_req) begin
            w_state_nxt = WRITE;
          end else begin
            w_wr_req_nxt = 1'b1;
            w_state_nxt  = WAIT_LO;
          end
        end else if (w_expire) begin
          w_lo_nxt    = 8'h00;
          w_drop_nxt  = 1'b1;
          w_state_nxt = WAIT_LO;
        end
      end
      WRITE: begin
        if (!wr_full && !r_wr_req) begin
          w_wr_req_nxt = 1'b1;
          w_state_nxt  = WAIT_LO;
          if (w_byte_ok) begin
            w_lo_nxt    = rx_data;
            w_timer_clr = 1'b1;
            w_state_nxt = WAIT_HI;
          end
        end else if (w_byte_ok && wr_full) begin
          w_ovf_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = WAIT_LO;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= WAIT_LO;
      r_lo      <= 8'h00;
      r_wr_data <= 16'h0000;
      r_wr_req  <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lo      <= w_lo_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_wr_req  <= w_wr_req_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_byte_err && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_ovf_inc && (r_ovf_cnt != {CNT_W{1'b1}})) begin
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign wr_clk     = ~SYS_CLK;
  assign wr_req     = r_wr_req;
  assign wr_data    = r_wr_data;
  assign drop_pulse = r_drop;
  assign err_cnt    = r_err_cnt;
  assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed byte sequences push expected
// words (with the cycle they must appear); a monitor pops on every wr_req.
module tb_uart_rx_ctrl;

  localparam int GAP = 20;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_err   = 1'b0;
  logic        wr_full  = 1'b0;
  logic        wr_clk;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        drop_pulse;
  logic [7:0]  err_cnt;
  logic [7:0]  ovf_cnt;

  uart_rx_ctrl #(
    .GAP_CYCLES(GAP),
    .CNT_W     (8)
  ) dut (
    .SYS_CLK   (clk),
    .RST_N     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .wr_full   (wr_full),
    .wr_clk    (wr_clk),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .drop_pulse(drop_pulse),
    .err_cnt   (err_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   n_drop   = 0;
  int   exp_drop = 0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic err, input int idle);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wr_req) begin
      chk("wr_req_not_consecutive", {31'b0, prev_req}, 32'd0);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got wr_data 0x%0h at cycle %0d, expected no write", wr_data, cyc);
      end else begin
        e = q.pop_front();
        chk("wr_data", {16'b0, wr_data}, {16'b0, e.data});
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (drop_pulse) n_drop++;
    prev_req <= wr_req;
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_req", {31'b0, wr_req}, 32'd0);
    chk("rst_wr_data", {16'b0, wr_data}, 32'd0);
    chk("rst_drop", {31'b0, drop_pulse}, 32'd0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("rst_ovf_cnt", {24'b0, ovf_cnt}, 32'd0);
    chk("wr_clk_clk_low", {31'b0, wr_clk}, 32'd1);
    @(posedge clk);
    #1;
    chk("wr_clk_clk_high", {31'b0, wr_clk}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic pair, one cycle latency
    send(8'h34, 1'b0, 1);
    push_exp(16'h1234, cyc + 1);
    send(8'h12, 1'b0, 3);

    // gap of exactly GAP idle cycles drops the low byte
    send(8'hAA, 1'b0, 0);
    repeat (GAP) @(negedge clk);
    exp_drop++;
    send(8'h55, 1'b0, 1);
    push_exp(16'h6655, cyc + 1);
    send(8'h66, 1'b0, 3);
    chk("drop_after_gap", n_drop, exp_drop);

    // high byte arriving in the timeout cycle is accepted
    send(8'h77, 1'b0, 0);
    repeat (GAP - 1) @(negedge clk);
    push_exp(16'h8877, cyc + 1);
    send(8'h88, 1'b0, 3);
    chk("no_drop_in_timeout_cycle", n_drop, exp_drop);

    // FIFO full: word held, extra byte counted as overflow
    wr_full = 1'b1;
    send(8'h01, 1'b0, 1);
    send(8'h02, 1'b0, 1);
    send(8'h03, 1'b0, 1);
    repeat (14) @(negedge clk);
    chk("ovf_cnt_full", {24'b0, ovf_cnt}, 32'd1);
    push_exp(16'h0201, cyc + 1);
    wr_full = 1'b0;
    repeat (3) @(negedge clk);

    // full clears with a byte in the same cycle, then an immediate high byte
    wr_full = 1'b1;
    send(8'hC1, 1'b0, 1);
    send(8'hC2, 1'b0, 1);
    push_exp(16'hC2C1, cyc + 1);
    push_exp(16'hD2D1, cyc + 3);
    wr_full = 1'b0;
    send(8'hD1, 1'b0, 0);
    send(8'hD2, 1'b0, 3);
    chk("ovf_cnt_unchanged", {24'b0, ovf_cnt}, 32'd1);

    // rx_err in WAIT_HI drops the low byte
    send(8'h10, 1'b0, 1);
    exp_drop++;
    send(8'hEE, 1'b1, 1);
    chk("err_cnt_wait_hi", {24'b0, err_cnt}, 32'd1);
    chk("drop_on_err", n_drop, exp_drop);
    send(8'h22, 1'b0, 1);
    push_exp(16'h1122, cyc + 1);
    send(8'h11, 1'b0, 3);

    // rx_err in WAIT_LO only counts
    send(8'h99, 1'b1, 1);
    chk("err_cnt_wait_lo", {24'b0, err_cnt}, 32'd2);
    send(8'h44, 1'b0, 1);
    push_exp(16'h3344, cyc + 1);
    send(8'h33, 1'b0, 3);
    chk("no_drop_err_wait_lo", n_drop, exp_drop);

    // back-to-back pairs every two cycles
    for (int i = 1; i <= 6; i++) begin
      if (i % 2 == 0) push_exp({i[7:0], 8'(i - 1)}, cyc + 1);
      send(i[7:0], 1'b0, 1);
    end
    repeat (3) @(negedge clk);

    // async reset while holding a low byte
    send(8'h5A, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_req", {31'b0, wr_req}, 32'd0);
    chk("arst_wr_data", {16'b0, wr_data}, 32'd0);
    chk("arst_drop", {31'b0, drop_pulse}, 32'd0);
    chk("arst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("arst_ovf_cnt", {24'b0, ovf_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h78, 1'b0, 1);
    push_exp(16'h5678, cyc + 1);
    send(8'h56, 1'b0, 3);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    chk("drop_total", n_drop, exp_drop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
